// File: rtl/uart_rx_edge_sampler.sv
// Oversampling front end of the UART receiver: edge/bit counters and a
// three-tap mid-bit majority vote feeding the RX control FSM.
module uart_rx_edge_sampler #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  edge_bit_en,
  input  logic                  dat_sam_en,
  output logic [PRESCALE_W-1:0] edge_count,
  output logic [BIT_CNT_W-1:0]  bit_count,
  output logic                  sampled_bit,
  output logic                  sampling_done
);

  localparam logic [PRESCALE_W-1:0] P_DEFAULT = PRESCALE_W'(8);
  localparam logic [PRESCALE_W-1:0] P_MIN     = PRESCALE_W'(6);
  localparam logic [PRESCALE_W-1:0] P_MAX     = PRESCALE_W'(32);

  logic [PRESCALE_W-1:0] p_lat_reg;
  logic                  s0_reg;
  logic                  s1_reg;
  logic                  s0_vld_reg;
  logic                  s1_vld_reg;

  logic [PRESCALE_W-1:0] p_next;
  logic [PRESCALE_W-1:0] p_last;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] tap0_idx;
  logic [PRESCALE_W-1:0] vote_idx;
  logic                  maj_next;
  logic                  sam_active;

  always_comb begin
    p_next     = ((Prescale < P_MIN) || (Prescale > P_MAX)) ? P_DEFAULT : Prescale;
    p_last     = p_lat_reg - PRESCALE_W'(1);
    half       = p_lat_reg >> 1;
    tap0_idx   = half - PRESCALE_W'(1);
    vote_idx   = half + PRESCALE_W'(1);
    maj_next   = (s0_reg & s1_reg) | (s0_reg & RX_IN) | (s1_reg & RX_IN);
    sam_active = edge_bit_en & dat_sam_en;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      p_lat_reg     <= P_DEFAULT;
      edge_count    <= '0;
      bit_count     <= '0;
      sampled_bit   <= 1'b1;
      sampling_done <= 1'b0;
      s0_reg        <= 1'b0;
      s1_reg        <= 1'b0;
      s0_vld_reg    <= 1'b0;
      s1_vld_reg    <= 1'b0;
    end else begin
      // The ratio only changes between frames, so a bit period never stretches mid-frame.
      if (!edge_bit_en) begin
        p_lat_reg  <= p_next;
        edge_count <= '0;
        bit_count  <= '0;
      end else if (edge_count == p_last) begin
        edge_count <= '0;
        if (bit_count != '1) begin
          bit_count <= bit_count + BIT_CNT_W'(1);
        end
      end else begin
        edge_count <= edge_count + PRESCALE_W'(1);
      end

      sampling_done <= 1'b0;
      if (sam_active) begin
        if (edge_count == tap0_idx) begin
          s0_reg     <= RX_IN;
          s0_vld_reg <= 1'b1;
        end
        if (edge_count == half) begin
          s1_reg     <= RX_IN;
          s1_vld_reg <= s0_vld_reg;
        end
        // A vote only counts when both earlier taps were taken in this bit.
        if (edge_count == vote_idx) begin
          if (s1_vld_reg) begin
            sampled_bit   <= maj_next;
            sampling_done <= 1'b1;
          end
          s0_vld_reg <= 1'b0;
          s1_vld_reg <= 1'b0;
        end
      end else begin
        s0_reg     <= 1'b0;
        s1_reg     <= 1'b0;
        s0_vld_reg <= 1'b0;
        s1_vld_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_edge_sampler.sv
// Directed bench for uart_rx_edge_sampler: a per-cycle vector table followed by
// hand-written sequences for prescale latching, saturation, glitches and enable drops.
module tb_uart_rx_edge_sampler;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       edge_bit_en;
  logic       dat_sam_en;
  logic [5:0] edge_count;
  logic [3:0] bit_count;
  logic       sampled_bit;
  logic       sampling_done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 CLK = ~CLK;

  uart_rx_edge_sampler #(.PRESCALE_W(6), .BIT_CNT_W(4)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .Prescale     (Prescale),
    .edge_bit_en  (edge_bit_en),
    .dat_sam_en   (dat_sam_en),
    .edge_count   (edge_count),
    .bit_count    (bit_count),
    .sampled_bit  (sampled_bit),
    .sampling_done(sampling_done)
  );

  typedef struct {
    logic       rst;
    logic       rx;
    logic [5:0] pre;
    logic       ebe;
    logic       dse;
    logic [5:0] exp_ec;
    logic [3:0] exp_bc;
    logic       exp_sb;
    logic       exp_done;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One cycle with edge_bit_en low latches the new ratio and clears the counters.
  task automatic restart(input logic [5:0] pre);
    Prescale    = pre;
    edge_bit_en = 1'b0;
    step();
    edge_bit_en = 1'b1;
  endtask

  function automatic void add(input logic rst, input logic rx, input logic [5:0] pre,
                              input logic ebe, input logic dse, input int ec, input int bc,
                              input logic sb, input logic done);
    vec_t v;
    v.rst = rst; v.rx = rx; v.pre = pre; v.ebe = ebe; v.dse = dse;
    v.exp_ec = 6'(ec); v.exp_bc = 4'(bc); v.exp_sb = sb; v.exp_done = done;
    vecs.push_back(v);
  endfunction

  initial begin
    int strobes;
    int n;

    // Reset with enables high and the line low: outputs must sit at reset values.
    add(1, 0, 8, 1, 1, 0, 0, 1, 0);
    add(1, 0, 8, 1, 1, 0, 0, 1, 0);
    // P=8, line held low: edge index k+1 mod 8, vote strobes at edge 6.
    for (int k = 0; k < 85; k++) begin
      n = k + 1;
      add(0, 0, 8, 1, 1, n % 8, n / 8, (k >= 5) ? 1'b0 : 1'b1, (n % 8) == 6);
    end
    // Now at edge 5, bit 10: a one-cycle enable drop clears both and kills the strobe.
    add(0, 0, 8, 0, 1, 0, 0, 0, 0);

    RST = 1'b1; RX_IN = 1'b0; Prescale = 6'd8; edge_bit_en = 1'b1; dat_sam_en = 1'b1;
    #2;
    for (int i = 0; i < vecs.size(); i++) begin
      RST = vecs[i].rst; RX_IN = vecs[i].rx; Prescale = vecs[i].pre;
      edge_bit_en = vecs[i].ebe; dat_sam_en = vecs[i].dse;
      step();
      $display("vec %0d: ec=%0d bc=%0d sb=%0b done=%0b", i, edge_count, bit_count,
               sampled_bit, sampling_done);
      check($sformatf("vec%0d_edge_count", i), edge_count, vecs[i].exp_ec);
      check($sformatf("vec%0d_bit_count", i), bit_count, vecs[i].exp_bc);
      check($sformatf("vec%0d_sampled_bit", i), sampled_bit, vecs[i].exp_sb);
      check($sformatf("vec%0d_sampling_done", i), sampling_done, vecs[i].exp_done);
    end

    // P=16: single low glitch at edge 8 is outvoted; two lows at edges 7,8 win.
    RX_IN = 1'b1;
    restart(6'd16);
    for (int j = 0; j < 32; j++) begin
      RX_IN = (j == 8 || j == 23 || j == 24) ? 1'b0 : 1'b1;
      step();
      if (j == 8)  check("p16_no_early_strobe", sampling_done, 0);
      if (j == 9) begin
        check("p16_glitch_ec", edge_count, 10);
        check("p16_glitch_done", sampling_done, 1);
        check("p16_glitch_sb", sampled_bit, 1);
        $display("p16 glitch bit: sb=%0b", sampled_bit);
      end
      if (j == 15) check("p16_period_bc", bit_count, 1);
      if (j == 25) begin
        check("p16_low_done", sampling_done, 1);
        check("p16_low_sb", sampled_bit, 0);
        $display("p16 low bit: sb=%0b", sampled_bit);
      end
    end

    // Prescale latched only while edge_bit_en is low; illegal values behave as 8.
    RX_IN = 1'b0;
    restart(6'd8);
    Prescale = 6'd16;
    run(8);
    check("pre_mid_frame_ec", edge_count, 0);
    check("pre_mid_frame_bc", bit_count, 1);
    restart(6'd16);
    run(8);
    check("pre16_half_ec", edge_count, 8);
    check("pre16_half_bc", bit_count, 0);
    run(8);
    check("pre16_full_bc", bit_count, 1);
    restart(6'd5);
    run(8);
    check("pre5_ec", edge_count, 0);
    check("pre5_bc", bit_count, 1);
    restart(6'd40);
    run(8);
    check("pre40_bc", bit_count, 1);
    restart(6'd6);
    run(6);
    check("pre6_ec", edge_count, 0);
    check("pre6_bc", bit_count, 1);
    $display("prescale latch sequence done");

    // P=32 for 20 bit periods: bit_count saturates at 15, one strobe per bit.
    restart(6'd32);
    strobes = 0;
    for (int j = 0; j < 640; j++) begin
      step();
      if (sampling_done) strobes++;
      if (j == 479) check("sat_bc_at_15", bit_count, 15);
    end
    check("sat_bc_stays", bit_count, 15);
    check("sat_ec_end", edge_count, 0);
    check("sat_strobes", strobes, 20);
    $display("p32 run: bc=%0d strobes=%0d", bit_count, strobes);

    // dat_sam_en drop between taps discards that bit's vote.
    restart(6'd8);
    for (int j = 0; j < 24; j++) begin
      RX_IN      = (j >= 8) ? 1'b1 : 1'b0;
      dat_sam_en = (j == 12) ? 1'b0 : 1'b1;
      step();
      if (j == 5) begin
        check("drop_bit0_done", sampling_done, 1);
        check("drop_bit0_sb", sampled_bit, 0);
      end
      if (j == 13) begin
        check("drop_bit1_no_strobe", sampling_done, 0);
        check("drop_bit1_sb_hold", sampled_bit, 0);
      end
      if (j == 21) begin
        check("drop_bit2_done", sampling_done, 1);
        check("drop_bit2_sb", sampled_bit, 1);
      end
    end
    $display("dat_sam_en drop sequence done");

    // Mid-frame reset overrides enables and restores the default ratio.
    restart(6'd16);
    run(3);
    RST = 1'b1;
    step();
    check("rst_mid_ec", edge_count, 0);
    check("rst_mid_bc", bit_count, 0);
    check("rst_mid_sb", sampled_bit, 1);
    check("rst_mid_done", sampling_done, 0);
    RST = 1'b0;
    run(8);
    check("rst_default_p_bc", bit_count, 1);
    check("rst_default_p_ec", edge_count, 0);
    $display("mid-frame reset sequence done");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
